// File: rtl/fan_speed_ctrl.sv
// Temperature-to-fan-speed controller: 4-sample moving average feeding a dwell-limited speed FSM.
// Optional build macro FAN_HYST_EN adds down-step hysteresis of HYST temperature units.
//
// state | meaning
// OFF   | fan stopped (average below T_LOW)
// LOW   | speed 1
// MID   | speed 2
// FULL  | speed 3; reset/fail-safe state and overtemp override
module fan_speed_ctrl #(
  parameter int DATA_W    = 8,
  parameter int AVG_LOG2  = 2,
  parameter int T_LOW     = 40,
  parameter int T_MID     = 60,
  parameter int T_HIGH    = 80,
  parameter int HYST      = 4,
  parameter int MIN_DWELL = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  output logic [1:0]        fan_speed,
  output logic              speed_valid,
  output logic [DATA_W-1:0] avg_temp,
  output logic              avg_valid,
  output logic              overtemp
);

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] MID  = 2'd2;
  localparam logic [1:0] FULL = 2'd3;

  localparam int DEPTH   = 1 << AVG_LOG2;
  localparam int SUM_W   = DATA_W + AVG_LOG2;
  localparam int FILL_W  = AVG_LOG2 + 1;
  localparam int DWELL_W = $clog2(MIN_DWELL + 1);

`ifdef FAN_HYST_EN
  localparam int HYST_EFF = HYST;
`else
  localparam int HYST_EFF = 0;
`endif

  localparam logic [DATA_W-1:0] TH_L = DATA_W'(T_LOW);
  localparam logic [DATA_W-1:0] TH_M = DATA_W'(T_MID);
  localparam logic [DATA_W-1:0] TH_H = DATA_W'(T_HIGH);
  // Down-step thresholds saturate at 0 when the hysteresis exceeds the threshold.
  localparam logic [DATA_W-1:0] TD_L = DATA_W'((T_LOW  > HYST_EFF) ? T_LOW  - HYST_EFF : 0);
  localparam logic [DATA_W-1:0] TD_M = DATA_W'((T_MID  > HYST_EFF) ? T_MID  - HYST_EFF : 0);
  localparam logic [DATA_W-1:0] TD_H = DATA_W'((T_HIGH > HYST_EFF) ? T_HIGH - HYST_EFF : 0);

  logic [DATA_W-1:0]  sbuf [DEPTH];
  logic [SUM_W-1:0]   sum;
  logic [FILL_W-1:0]  fill_cnt;
  logic               upd;
  logic               accept;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         state;
  logic [1:0]         tgt;
  logic [1:0]         hyst_lvl;
  logic [1:0]         nxt;

  function automatic logic [1:0] level(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] t1,
                                       input logic [DATA_W-1:0] t2,
                                       input logic [DATA_W-1:0] t3);
    if (a >= t3)      return FULL;
    else if (a >= t2) return MID;
    else if (a >= t1) return LOW;
    else              return OFF;
  endfunction

  assign accept    = sample_valid && sample_ready;
  assign fan_speed = state;
  assign overtemp  = avg_valid && (avg_temp >= TH_H);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) sbuf[i] <= '0;
      sum          <= '0;
      fill_cnt     <= '0;
      upd          <= 1'b0;
      sample_ready <= 1'b1;
      avg_temp     <= '0;
      avg_valid    <= 1'b0;
    end else begin
      upd          <= accept;
      sample_ready <= !accept;
      if (accept) begin
        sbuf[0] <= sample_data;
        for (int i = 1; i < DEPTH; i++) sbuf[i] <= sbuf[i-1];
        sum <= sum + SUM_W'(sample_data) - SUM_W'(sbuf[DEPTH-1]);
        if (fill_cnt != FILL_W'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
      end
      if (upd) begin
        avg_temp  <= DATA_W'(sum >> AVG_LOG2);
        avg_valid <= (fill_cnt == FILL_W'(DEPTH));
      end
    end
  end

  // A down-step lands no lower than the plain target and no higher than the current state.
  always_comb begin
    tgt      = level(avg_temp, TH_L, TH_M, TH_H);
    hyst_lvl = level(avg_temp, TD_L, TD_M, TD_H);
    nxt      = tgt;
    if (tgt < state) nxt = (hyst_lvl > state) ? state : hyst_lvl;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= FULL;
      speed_valid <= 1'b0;
      dwell       <= '0;
    end else begin
      speed_valid <= 1'b0;
      if (avg_valid && (nxt != state) && ((dwell == '0) || (tgt == FULL))) begin
        state       <= nxt;
        speed_valid <= 1'b1;
        dwell       <= DWELL_W'(MIN_DWELL - 1);
      end else if (dwell != '0) begin
        dwell <= dwell - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Bench for fan_speed_ctrl: directed scenarios plus a random run, all checked against a
// window-averaging / time-since-last-change reference model.
module tb_fan_speed_ctrl;
  localparam int T_LOW = 40, T_MID = 60, T_HIGH = 80, HYST = 4, MIN_DWELL = 1000;
  localparam logic [13:0] RST_VEC = {1'b1, 2'd3, 1'b0, 8'd0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = 8'd0;
  logic       sample_ready, speed_valid, avg_valid, overtemp;
  logic [1:0] fan_speed;
  logic [7:0] avg_temp;
  logic [13:0] dvec;

  int total = 0;
  int bad = 0;

  fan_speed_ctrl #(.DATA_W(8), .AVG_LOG2(2), .T_LOW(T_LOW), .T_MID(T_MID), .T_HIGH(T_HIGH),
                   .HYST(HYST), .MIN_DWELL(MIN_DWELL)) dut (
    .CLK(clk), .RST(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .fan_speed(fan_speed), .speed_valid(speed_valid),
    .avg_temp(avg_temp), .avg_valid(avg_valid), .overtemp(overtemp));

  always #5 clk = ~clk;
  assign dvec = {sample_ready, fan_speed, speed_valid, avg_temp, avg_valid, overtemp};

  // Reference model: last four accepted samples, integer mean, and a change rule
  // based on the number of edges since the previous speed change.
  int     q[$];
  int     m_avg, m_speed;
  logic   m_ready, m_pend, m_pulse, m_avg_valid;
  longint cyc, last_chg;

  function automatic int target(input int avg, input int cur);
    int thr[4];
    int up;
    int res;
    thr = '{0, T_LOW, T_MID, T_HIGH};
    up = 0;
    for (int k = 1; k <= 3; k++) if (avg >= thr[k]) up = k;
    res = up;
`ifdef FAN_HYST_EN
    if (up < cur) begin
      res = cur;
      for (int k = cur - 1; k >= up; k--) begin
        if (avg < ((thr[k+1] > HYST) ? thr[k+1] - HYST : 0)) res = k;
        else break;
      end
    end
`else
    if (cur < 0) res = 0;
`endif
    return res;
  endfunction

  task automatic model_edge();
    int nt, s;
    logic acc;
    if (rst) begin
      q.delete();
      m_avg = 0; m_avg_valid = 1'b0; m_speed = 3; m_pulse = 1'b0;
      m_ready = 1'b1; m_pend = 1'b0; cyc = 0; last_chg = -100000;
    end else begin
      cyc++;
      acc = sample_valid && m_ready;
      nt = target(m_avg, m_speed);
      m_pulse = 1'b0;
      if (m_avg_valid && nt != m_speed && ((cyc - last_chg) >= MIN_DWELL || nt == 3)) begin
        m_speed = nt; m_pulse = 1'b1; last_chg = cyc;
      end
      if (m_pend) begin
        s = 0;
        foreach (q[i]) s += q[i];
        m_avg = s / 4;
        m_avg_valid = (q.size() == 4);
      end
      if (acc) begin
        q.push_back(int'(sample_data));
        if (q.size() > 4) void'(q.pop_front());
      end
      m_pend = acc;
      m_ready = !acc;
    end
  endtask

  always @(posedge clk or posedge rst) model_edge();

  function automatic logic [13:0] mvec();
    return {m_ready, 2'(m_speed), m_pulse, 8'(m_avg), m_avg_valid,
            (m_avg_valid && m_avg >= T_HIGH)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int npulse = 0;
    rst = 1'b1; sample_valid = 1'b0;
    tick(); tick();
    total++;
    if (dvec !== RST_VEC) begin bad++; $display("FAIL reset_vals got=%h want=%h", dvec, RST_VEC); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        sample_valid = (p == 0); sample_data = 8'd20;
        tick();
        if (speed_valid) npulse++;
        total++;
        if (dvec !== mvec()) begin bad++; $display("FAIL reset_fill got=%h want=%h", dvec, mvec()); end
      end
      if (i == 2) begin
        total++;
        if ({fan_speed, avg_valid, npulse[0]} !== {2'd3, 1'b0, 1'b0} || npulse != 0) begin
          bad++; $display("FAIL failsafe got=spd%0d av%0d pulses%0d want=spd3 av0 pulses0",
                          fan_speed, avg_valid, npulse);
        end
      end
    end
    total++;
    if (avg_temp !== 8'd20 || avg_valid !== 1'b1) begin
      bad++; $display("FAIL first_avg got=%0d/%0d want=20/1", avg_temp, avg_valid);
    end
    tick();
    if (speed_valid) npulse++;
    total++;
    if (fan_speed !== 2'd0 || speed_valid !== 1'b1) begin
      bad++; $display("FAIL first_drop got=spd%0d sv%0d want=spd0 sv1", fan_speed, speed_valid);
    end
    repeat (3) begin tick(); if (speed_valid) npulse++; end
    total++;
    if (npulse != 1) begin bad++; $display("FAIL first_pulses got=%0d want=1", npulse); end
  endtask

  // Leaves the DUT at speed 1 having just changed; returns edges since that change.
  task automatic test_averaging(output int since);
    int vals[4];
    vals = '{10, 20, 30, 45};
    do_reset();
    since = 0;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        sample_valid = (p == 0); sample_data = 8'(vals[i]);
        tick();
        total++;
        if (dvec !== mvec()) begin bad++; $display("FAIL avg_fill got=%h want=%h", dvec, mvec()); end
      end
    end
    total++;
    if (avg_temp !== 8'd26) begin bad++; $display("FAIL avg26 got=%0d want=26", avg_temp); end
    tick();
    total++;
    if (fan_speed !== 2'd0) begin bad++; $display("FAIL avg26_spd got=%0d want=0", fan_speed); end
    sample_valid = 1'b1; sample_data = 8'd100; tick(); since++;
    sample_valid = 1'b0; tick(); since++;
    total++;
    if (avg_temp !== 8'd48 || fan_speed !== 2'd0) begin
      bad++; $display("FAIL avg48 got=%0d/spd%0d want=48/spd0", avg_temp, fan_speed);
    end
    while (fan_speed != 2'd1 && since < 1200) begin
      tick(); since++;
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL avg_dwell got=%h want=%h", dvec, mvec()); end
    end
    total++;
    if (fan_speed !== 2'd1 || since != MIN_DWELL) begin
      bad++; $display("FAIL avg_step_up got=spd%0d at%0d want=spd1 at%0d", fan_speed, since, MIN_DWELL);
    end
    since = 0;
  endtask

  task automatic test_dwell();
    int since = 0, npulse = 0;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        sample_valid = (p == 0); sample_data = 8'd65;
        tick(); since++;
        if (speed_valid) npulse++;
        total++;
        if (fan_speed !== 2'd1 || dvec !== mvec()) begin
          bad++; $display("FAIL dwell_hold got=%h want=%h", dvec, mvec());
        end
      end
    end
    while (fan_speed != 2'd2 && since < 1200) begin
      tick(); since++;
      if (speed_valid) npulse++;
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL dwell_wait got=%h want=%h", dvec, mvec()); end
    end
    total++;
    if (fan_speed !== 2'd2 || since != MIN_DWELL || npulse != 1) begin
      bad++; $display("FAIL dwell_step got=spd%0d at%0d pulses%0d want=spd2 at%0d pulses1",
                      fan_speed, since, npulse, MIN_DWELL);
    end
  endtask

  task automatic test_overtemp();
    int t = 0, t_ot = -1, t_f3 = -1;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        sample_valid = (p == 0); sample_data = 8'd90;
        tick(); t++;
        if (overtemp && t_ot < 0) t_ot = t;
        if (fan_speed == 2'd3 && t_f3 < 0) t_f3 = t;
        total++;
        if (dvec !== mvec()) begin bad++; $display("FAIL ot_seq got=%h want=%h", dvec, mvec()); end
      end
    end
    total++;
    if (overtemp !== 1'b1 || fan_speed !== 2'd3 || t_ot < 0 || (t_f3 - t_ot) != 1) begin
      bad++; $display("FAIL ot_override got=ot%0d spd%0d lag%0d want=ot1 spd3 lag1",
                      overtemp, fan_speed, t_f3 - t_ot);
    end
  endtask

  task automatic test_hyst();
    logic [1:0] exp58;
`ifdef FAN_HYST_EN
    exp58 = 2'd2;
`else
    exp58 = 2'd1;
`endif
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sample_valid = (i % 2 == 0); sample_data = 8'd70; tick();
    end
    repeat (MIN_DWELL + 10) begin
      tick();
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL hyst_settle got=%h want=%h", dvec, mvec()); end
    end
    total++;
    if (fan_speed !== 2'd2) begin bad++; $display("FAIL hyst_mid got=%0d want=2", fan_speed); end
    for (int i = 0; i < 10; i++) begin
      sample_valid = (i % 2 == 0) && (i < 8); sample_data = 8'd58; tick();
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL hyst58_seq got=%h want=%h", dvec, mvec()); end
    end
    total++;
    if (avg_temp !== 8'd58 || fan_speed !== exp58) begin
      bad++; $display("FAIL hyst58 got=%0d/spd%0d want=58/spd%0d", avg_temp, fan_speed, exp58);
    end
    for (int i = 0; i < 10; i++) begin
      sample_valid = (i % 2 == 0) && (i < 8); sample_data = 8'd55; tick();
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL hyst55_seq got=%h want=%h", dvec, mvec()); end
    end
    total++;
    if (avg_temp !== 8'd55 || fan_speed !== 2'd1) begin
      bad++; $display("FAIL hyst55 got=%0d/spd%0d want=55/spd1", avg_temp, fan_speed);
    end
  endtask

  task automatic test_handshake_reset();
    logic [7:0] d[12];
    int exp_avg;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      d[k] = 8'($urandom_range(0, 255));
      sample_valid = 1'b1; sample_data = d[k];
      tick();
      total++;
      if (sample_ready !== ((k + 1) % 2 == 0) || dvec !== mvec()) begin
        bad++; $display("FAIL hs_ready k=%0d got=%h want=%h", k, dvec, mvec());
      end
    end
    exp_avg = (int'(d[4]) + int'(d[6]) + int'(d[8]) + int'(d[10])) / 4;
    total++;
    if (avg_temp !== 8'(exp_avg) || avg_valid !== 1'b1) begin
      bad++; $display("FAIL hs_avg got=%0d/%0d want=%0d/1", avg_temp, avg_valid, exp_avg);
    end
    rst = 1'b1;
    #1;
    total++;
    if (dvec !== RST_VEC) begin bad++; $display("FAIL hs_midreset got=%h want=%h", dvec, RST_VEC); end
    tick();
    sample_valid = 1'b0; rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample_valid = (k % 2 == 0); sample_data = 8'd30; tick();
      total++;
      if (avg_valid !== 1'b0 || dvec !== mvec()) begin
        bad++; $display("FAIL hs_refill got=%h want=%h", dvec, mvec());
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_random();
    int temp = 50;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      temp += $urandom_range(0, 24) - 12;
      if (temp < 0) temp = 0;
      if (temp > 255) temp = 255;
      sample_valid = ($urandom_range(0, 2) != 0);
      sample_data = 8'((temp + $urandom_range(0, 6) > 255) ? 255 : temp + $urandom_range(0, 6));
      rst = ($urandom_range(0, 1499) == 0);
      tick();
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL rand n=%0d got=%h want=%h", n, dvec, mvec()); end
    end
    rst = 1'b0; sample_valid = 1'b0;
  endtask

  initial begin
    int since;
    test_reset();
    test_averaging(since);
    test_dwell();
    test_overtemp();
    test_hyst();
    test_handshake_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
